// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch front end with a single outstanding memory request,
// an in-order {pc, instr} FIFO toward decode, and redirect-driven flushing.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        flushing
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [31:0] fetch_pc_q, fetch_pc_d, pending_pc_q, pending_pc_d;
  logic        outstanding_q, outstanding_d, drop_q, drop_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0] pc_mem_q [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];
  logic        accept, resp, push, pop;
  // the pending request already owns a FIFO slot, so it counts toward fullness
  assign imem_req_valid = !reset && !redirect && !outstanding_q &&
                          ((count_q + (AW+1)'(outstanding_q)) < FULL);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp           = imem_resp_valid && outstanding_q;
  assign push           = resp && !drop_q && !redirect;
  assign pop            = out_valid && out_ready && !redirect;
  assign out_valid      = count_q != '0;
  assign out_instr      = out_valid ? instr_mem_q[rd_q] : NOP;
  assign out_pc         = out_valid ? pc_mem_q[rd_q] : 32'h0;
  assign flushing       = drop_q;
  always_comb begin
    fetch_pc_d    = redirect ? {redirect_pc[31:2], 2'b00} : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    pending_pc_d  = accept ? fetch_pc_q : pending_pc_q;
    outstanding_d = resp ? 1'b0 : accept ? 1'b1 : outstanding_q;
    drop_d        = redirect ? (outstanding_q && !imem_resp_valid) : resp ? 1'b0 : drop_q;
    count_d       = redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_d          = redirect ? '0 : rd_q + AW'(pop);
    wr_d          = redirect ? '0 : wr_q + AW'(push);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      pending_pc_q  <= 32'h0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      count_q       <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pending_pc_q  <= pending_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem_q[wr_q]    <= pending_pc_q;
      instr_mem_q[wr_q] <= imem_resp_data;
    end
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch front end. Owns the fetch PC, issues word requests to instruction memory, and queues returned {pc, instr} pairs in a small FIFO.
- Presents one instruction per cycle to decode through a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage (originPc/pcBranch). A redirect flushes queued and in-flight instructions.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
RESET_PC, 32'h00000000, fetch PC after reset
NOP, 32'h00000013, value driven on out_instr when FIFO empty

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response data valid (in order, >=1 cycle after accept)
imem_resp_data  input  32  returned instruction word
redirect  input  1  taken branch/jump from execute (originPc)
redirect_pc  input  32  branch target (pcBranch)
out_valid  output  1  instruction available to decode
out_ready  input  1  decode consumes this cycle
out_instr  output  32  head instruction
out_pc  output  32  PC of head instruction
flushing  output  1  high while a dropped response is still outstanding

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high; it is sampled only on the clk rising edge.
  - Reset values: fetch_pc=RESET_PC, FIFO empty (count=0, rd/wr ptr=0), outstanding=0, drop=0.
  - Output reset values: imem_req_valid=0, out_valid=0, out_instr=NOP, out_pc=0, flushing=0.
  - Reset asserted mid-transaction also clears outstanding and drop. The bench must not return a stale response after reset.
- Issue:
  - At most one outstanding request.
  - imem_req_valid = !reset && !redirect && !outstanding && (count < DEPTH). It is combinational from registered state plus redirect.
  - imem_req_addr = fetch_pc.
- On accept (req_valid && req_ready):
  - pending_pc <= fetch_pc
  - fetch_pc <= fetch_pc + 4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000)
  - outstanding <= 1
- Response:
  - When imem_resp_valid && outstanding: outstanding <= 0.
  - If drop=0 and no redirect in the same cycle: push {pending_pc, imem_resp_data}.
  - Otherwise the response is discarded and drop <= 0.
  - imem_resp_valid with outstanding=0 is ignored.
  - Space for the push is guaranteed because issue required count < DEPTH, counting the pending slot. The count check uses count + outstanding < DEPTH.
- Output:
  - out_valid = (count != 0); out_instr/out_pc = FIFO head. When empty: out_instr=NOP, out_pc=0.
  - Pop on out_valid && out_ready. Push and pop in the same cycle leaves count unchanged.
- Redirect (highest priority):
  - Next edge: FIFO emptied (count=0, ptrs=0); fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - drop <= outstanding && !imem_resp_valid.
  - A pop in the redirect cycle has no effect on state; decode squashes that instruction itself.
  - The first request to the target issues the cycle after redirect, provided no outstanding response remains.
  - While drop=1, no new request issues until the stale response returns.
- flushing = drop.
- Latency:
  - Redirect to first target request: 1 cycle, or later if a response is outstanding.
  - Response to out_valid: 1 cycle (registered FIFO).
  - Best-case throughput with 1-cycle memory: one instruction every 2 cycles, due to the single-outstanding limit.
- Full: with count=DEPTH, no request is issued. Once a pop occurs, issue resumes the next cycle.

Test Plan:
1. Reset then stream, 1-cycle memory returning mem[addr]=addr|0xA0000000, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC; out_instr 0xA0000000,0xA0000004,...; no gaps beyond the 2-cycle cadence.
2. out_ready=0 for 20 cycles -> exactly DEPTH=4 entries captured (pc 0x0..0xC), imem_req_valid=0 thereafter. Raise out_ready -> entries drain in order, fetch resumes at 0x10.
3. Redirect to 0x00000102 with 2 entries queued and one request outstanding -> next cycle out_valid=0 and flushing=1. Stale response dropped. Next request addr 0x00000100; first out_pc=0x100.
4. Redirect in the same cycle as imem_resp_valid -> response discarded, flushing stays 0, request to target issues next cycle.
5. fetch_pc=0xFFFFFFFC after redirect -> requests 0xFFFFFFFC then 0x00000000. Out order preserved.
6. Reset asserted while a request is outstanding and 3 entries queued -> next cycle out_valid=0, out_instr=NOP, imem_req_addr=RESET_PC, imem_req_valid=1 after reset deasserts.
